regfile_dump_ctrl: RTL and testbench

Debug-path controller that sequences a full dump of the MIPS register file over a byte-wide valid/ready stream, typically to the UART transmitter of the debug unit. While idle it passes the pipeline's read-port-1 address straight through. When a dump is started it takes over read port 1, stalls the pipeline, and sends every register MSB-first. It sits between the decode stage, the register file and the debug unit's TX path.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/word_tx_serializer.sv | 63 ++++++
 rtl/regfile_dump_ctrl.sv | 96 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS debug-path constants: stream byte geometry and the dump FSM state encoding.
// The debug unit imports this package as well.
package mips_pkg;

    localparam int NB_BYTE        = 8;
    localparam int NB_DATA        = 32;
    localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_CAPT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_CAPT = ST_CAPT,
        S_SEND = ST_SEND,
        S_DONE = ST_DONE
    } dump_state_e;

endpackage

// File: rtl/word_tx_serializer.sv
// Turns one loaded word into an MSB-first byte stream with valid/ready handshaking.
// Valid and data come only from registers, so there is no path from ready_i to them.
module word_tx_serializer
    import mips_pkg::*;
#(
    parameter int NB_DATA = mips_pkg::NB_DATA,
    parameter int NB_BYTE = mips_pkg::NB_BYTE
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] word_i,
    input  logic               ready_i,
    output logic [NB_BYTE-1:0] data_o,
    output logic               valid_o,
    output logic               last_o,
    output logic               fire_o
);

    localparam int BPW   = NB_DATA / NB_BYTE;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;

    // Handshake: a byte is transferred on every rising edge where valid_o and
    // ready_i are both high; valid_o is never withdrawn before that happens.
    assign data_o  = shift_q[NB_DATA-1 -: NB_BYTE];
    assign valid_o = valid_q;
    assign last_o  = (cnt_q == CNT_W'(BPW - 1));
    assign fire_o  = valid_q & ready_i;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = word_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (fire_o) begin
            shift_d = shift_q << NB_BYTE;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_o) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Dumps every register of the MIPS register file over a byte stream, borrowing
// read port 1 and stalling the pipeline while the dump runs.
module regfile_dump_ctrl
    import mips_pkg::*;
#(
    parameter int NB_DATA = mips_pkg::NB_DATA,
    parameter int NB_ADDR = 5,
    parameter int NB_BYTE = mips_pkg::NB_BYTE
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_cpu_rd_addr1,
    output logic [NB_ADDR-1:0] o_rf_rd_addr1,
    input  logic [NB_DATA-1:0] i_rf_rd_data1,
    output logic               o_stall,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [2:0]         o_dbg_state
);

    dump_state_e        state_q, state_d;
    logic [NB_ADDR-1:0] idx_q, idx_d;
    logic               load;
    logic               ser_last;
    logic               ser_fire;

    word_tx_serializer #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .load_i  (load),
        .word_i  (i_rf_rd_data1),
        .ready_i (i_tx_ready),
        .data_o  (o_tx_data),
        .valid_o (o_tx_valid),
        .last_o  (ser_last),
        .fire_o  (ser_fire)
    );

    assign o_busy      = (state_q != S_IDLE);
    assign o_stall     = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_dbg_state = state_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        load          = 1'b0;
        o_rf_rd_addr1 = idx_q;
        case (state_q)
            S_IDLE: begin
                o_rf_rd_addr1 = i_cpu_rd_addr1;
                if (i_start) begin
                    idx_d   = '0;
                    state_d = S_REQ;
                end
            end
            // Register file samples idx at the closing edge of REQ; data is
            // available during CAPT.
            S_REQ:  state_d = S_CAPT;
            S_CAPT: begin
                load    = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (ser_fire && ser_last) begin
                    if (idx_q == {NB_ADDR{1'b1}}) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + NB_ADDR'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: a register file model feeds port 1,
// expected bytes are queued per dump and a negedge monitor pops and compares.
module tb_regfile_dump_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [4:0]  i_cpu_rd_addr1 = '0;
    logic [4:0]  o_rf_rd_addr1;
    logic [31:0] i_rf_rd_data1 = '0;
    logic        o_stall;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic [2:0]  o_dbg_state;

    regfile_dump_ctrl dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_cpu_rd_addr1 (i_cpu_rd_addr1),
        .o_rf_rd_addr1  (o_rf_rd_addr1),
        .i_rf_rd_data1  (i_rf_rd_data1),
        .o_stall        (o_stall),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- clock / register file model ----------------
    always #5 clk = ~clk;

    logic [31:0] regs [32];
    always @(posedge clk) i_rf_rd_data1 <= regs[o_rf_rd_addr1];

    bit rdy_rand = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rdy_rand) i_tx_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- scoreboard state ----------------
    logic [7:0]  exp_q [$];
    logic [31:0] exp_words [32];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, req_cyc = 0, done_cyc = 0;
    int n_bytes = 0, n_done = 0, stall_bad = 0, exp_idx = 0;
    bit in_dump = 1'b0;
    bit hold_pending = 1'b0;
    logic [7:0] held_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!i_rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (o_dbg_state == ST_REQ) begin
                if (!in_dump) begin
                    in_dump = 1'b1;
                    req_cyc = cyc;
                end
                check("req_addr", {27'd0, o_rf_rd_addr1}, exp_idx);
                exp_idx++;
            end
            if ((o_dbg_state != ST_IDLE) && !(o_stall && o_busy)) stall_bad++;
            if ((o_dbg_state == ST_IDLE) && (o_stall || o_busy)) stall_bad++;
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
                in_dump  = 1'b0;
            end
            if (hold_pending) begin
                check("hold_valid", {31'd0, o_tx_valid}, 32'd1);
                check("hold_data", {24'd0, o_tx_data}, {24'd0, held_data});
            end
            hold_pending = o_tx_valid && !i_tx_ready;
            held_data    = o_tx_data;
            if (o_tx_valid && i_tx_ready) begin
                n_bytes++;
                if (exp_q.size() == 0) begin
                    check("extra_byte", {24'd0, o_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, o_tx_data}, {24'd0, e});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_dump();
        for (int k = 0; k < 32; k++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(exp_words[k][8*b +: 8]);
            end
        end
    endtask

    task automatic run_dump(input int budget);
        n_bytes = 0; n_done = 0; stall_bad = 0; exp_idx = 0; in_dump = 1'b0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int c = 0; c < budget && n_done == 0; c++) @(negedge clk);
        if (n_done == 0) check("dump_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_dump(input bit timed);
        check("byte_count", n_bytes, 32'd128);
        check("done_pulses", n_done, 32'd1);
        check("stall_busy", stall_bad, 32'd0);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("end_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        if (timed) check("done_cycle", done_cyc - req_cyc, 32'd192);
    endtask

    task automatic wait_req_idx(input logic [4:0] idx);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 3000 && !hit; c++) begin
            @(negedge clk);
            if (o_dbg_state == ST_REQ && o_rf_rd_addr1 == idx) hit = 1'b1;
        end
        if (!hit) check("wait_req_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 32; k++) begin
            regs[k]      = 32'h0101_0101 * k;
            exp_words[k] = 32'h0101_0101 * k;
        end

        // Reset state
        #12;
        check("rst_valid", {31'd0, o_tx_valid}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_data", {24'd0, o_tx_data}, 32'd0);
        check("rst_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        @(negedge clk); i_rst_n = 1'b1;

        // Idle pass-through
        @(negedge clk); i_cpu_rd_addr1 = 5'd17; #1;
        check("idle_pass_17", {27'd0, o_rf_rd_addr1}, 32'd17);
        i_cpu_rd_addr1 = 5'd9; #1;
        check("idle_pass_9", {27'd0, o_rf_rd_addr1}, 32'd9);
        i_cpu_rd_addr1 = 5'd17;

        // Full dump, ready high
        push_dump();
        run_dump(400);
        check_dump(1'b1);

        // r1 = DEADBEEF with random ready
        regs[1] = 32'hDEAD_BEEF; exp_words[1] = 32'hDEAD_BEEF;
        push_dump();
        rdy_rand = 1'b1;
        run_dump(3000);
        rdy_rand = 1'b0;
        @(posedge clk); #2 i_tx_ready = 1'b1;
        check_dump(1'b0);

        // Reset in the middle of sending register 10
        push_dump();
        n_bytes = 0; n_done = 0; exp_idx = 0; in_dump = 1'b0;
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int c = 0; c < 400 && !hit; c++) begin
                @(negedge clk);
                if (o_dbg_state == ST_SEND && exp_idx == 11) hit = 1'b1;
            end
            if (!hit) check("reg10_timeout", 32'd0, 32'd1);
        end
        i_rst_n = 1'b0; #1;
        check("midrst_valid", {31'd0, o_tx_valid}, 32'd0);
        check("midrst_stall", {31'd0, o_stall}, 32'd0);
        check("midrst_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
        check("midrst_data", {24'd0, o_tx_data}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;

        // Fresh dump from r0, with r3 written on the negedge of its REQ cycle
        exp_words[3] = 32'hCAFE_F00D;
        push_dump();
        fork
            run_dump(400);
            begin
                wait_req_idx(5'd3);
                regs[3] = 32'hCAFE_F00D;
            end
        join
        check_dump(1'b1);

        // Extra start pulse mid-dump is ignored
        push_dump();
        fork
            run_dump(400);
            begin
                repeat (50) @(posedge clk);
                #2 i_start = 1'b1;
                @(posedge clk); #2 i_start = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check_dump(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
